// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage with an integrated IF/ID pipeline register. Holds the
// program counter, reads a byte-addressed instruction memory (big- or
// little-endian word assembly) and presents a registered instruction, its PC,
// PC+4 and a valid bit to decode. Supports stall, redirect and flush.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   PC_write          1 advances the PC, 0 stalls the PC and IF/ID
//   redirect_valid    taken branch/jump this cycle (overrides PC_write=0)
//   redirect_pc       redirect target (low two bits dropped, misalignment faults)
//   flush             squash IF/ID contents into a bubble
//   prog_we/addr/data byte write port into instruction memory
//   pc_o              current fetch PC
//   ifid_instr/pc/pc4 registered instruction, its PC and PC+4
//   ifid_valid        IF/ID holds a real fetched instruction
//   fetch_fault       sticky out-of-range fetch / misaligned redirect flag
// ----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     MEM_BYTES  = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter bit              BIG_ENDIAN = 1'b1,
  parameter                  INIT_FILE  = "",
  parameter logic [31:0]     NOP        = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            PC_write,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            flush,
  input  logic            prog_we,
  input  logic [XLEN-1:0] prog_addr,
  input  logic [7:0]      prog_data,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     ifid_instr,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pc4,
  output logic            ifid_valid,
  output logic            fetch_fault
);

  localparam int unsigned     IDX_W     = $clog2(MEM_BYTES);
  localparam logic [XLEN-1:0] LAST_WORD = XLEN'(MEM_BYTES - 4);
  localparam logic [XLEN-1:0] MEM_SIZE  = XLEN'(MEM_BYTES);
  localparam logic [XLEN-1:0] FOUR      = XLEN'(4);

  // --------------------------------------------------------------------------
  // Instruction memory
  // --------------------------------------------------------------------------
  logic [7:0] mem_q [MEM_BYTES] = '{default: 8'h00};

  // NOTE: the memory array has no reset branch on purpose; resetting a RAM
  // would force it into flops and would wipe the program on every reset.
  always_ff @(posedge clk) begin
    if (prog_we && (prog_addr < MEM_SIZE)) begin
      mem_q[prog_addr[IDX_W-1:0]] <= prog_data;
    end
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] pc_q,         pc_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0] ifid_pc_q,    ifid_pc_d;
  logic [XLEN-1:0] ifid_pc4_q,   ifid_pc4_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic            fault_q,      fault_d;

  // --------------------------------------------------------------------------
  // Combinational fetch
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] idx;
  logic [7:0]       b0, b1, b2, b3;
  logic             in_range;
  logic [31:0]      fetch_word;
  logic [XLEN-1:0]  pc_plus4;
  logic             ifid_load;
  logic             redirect_misaligned;

  assign idx      = pc_q[IDX_W-1:0];
  assign b0       = mem_q[idx];
  assign b1       = mem_q[idx + IDX_W'(1)];
  assign b2       = mem_q[idx + IDX_W'(2)];
  assign b3       = mem_q[idx + IDX_W'(3)];
  // The PC is always word-aligned, so the last legal fetch starts at MEM_BYTES-4.
  assign in_range = (pc_q <= LAST_WORD);
  assign pc_plus4 = pc_q + FOUR;

  assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
  // IF/ID captures the fetched word only when neither squashed nor stalled.
  assign ifid_load = !redirect_valid && !flush && PC_write;

  always_comb begin
    fetch_word = NOP;
    if (in_range) begin
      fetch_word = BIG_ENDIAN ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path through
  // the if/else chain can leave a variable unassigned and infer a latch.
  always_comb begin
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    fault_d      = fault_q;

    if (redirect_valid) begin
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (PC_write) begin
      pc_d = pc_plus4;
    end

    if (redirect_valid || flush) begin
      // Bubble: the PC fields keep their last values.
      ifid_instr_d = NOP;
      ifid_valid_d = 1'b0;
    end else if (PC_write) begin
      ifid_instr_d = fetch_word;
      ifid_pc_d    = pc_q;
      ifid_pc4_d   = pc_plus4;
      ifid_valid_d = 1'b1;
    end

    if (redirect_misaligned || (ifid_load && !in_range)) begin
      fault_d = 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      ifid_instr_q <= NOP;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      fault_q      <= fault_d;
    end
  end

  assign pc_o        = pc_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_pc4    = ifid_pc4_q;
  assign ifid_valid  = ifid_valid_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Drives a big-endian and a little-endian instance (both MEM_BYTES=16) from the
// same stimulus. A table of {controls, expected outputs} covers fetch, stall,
// redirect, flush and out-of-range fetch; hand-written sequences cover async
// reset, misaligned redirect, PC wrap and the program write port.
// ----------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [7:0]  prog_data;

  logic [31:0] be_pc_o, be_instr, be_ipc, be_ipc4;
  logic        be_valid, be_fault;
  logic [31:0] le_pc_o, le_instr, le_ipc, le_ipc4;
  logic        le_valid, le_fault;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .XLEN(32), .MEM_BYTES(16), .RESET_PC(32'd0), .BIG_ENDIAN(1'b1),
    .INIT_FILE(""), .NOP(NOP)
  ) u_dut_be (
    .clk(clk), .rst_n(rst_n), .PC_write(pc_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .pc_o(be_pc_o), .ifid_instr(be_instr), .ifid_pc(be_ipc),
    .ifid_pc4(be_ipc4), .ifid_valid(be_valid), .fetch_fault(be_fault)
  );

  if_fetch_unit #(
    .XLEN(32), .MEM_BYTES(16), .RESET_PC(32'd0), .BIG_ENDIAN(1'b0),
    .INIT_FILE(""), .NOP(NOP)
  ) u_dut_le (
    .clk(clk), .rst_n(rst_n), .PC_write(pc_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .pc_o(le_pc_o), .ifid_instr(le_instr), .ifid_pc(le_ipc),
    .ifid_pc4(le_ipc4), .ifid_valid(le_valid), .fetch_fault(le_fault)
  );

  typedef struct {
    logic        pw;
    logic        rv;
    logic        fl;
    logic [31:0] rpc;
    logic [31:0] e_pc_o;
    logic [31:0] e_instr_be;
    logic [31:0] e_instr_le;
    logic [31:0] e_ipc;
    logic [31:0] e_ipc4;
    logic        e_valid;
    logic        e_fault;
  } vec_t;

  vec_t       vecs [13];
  logic [7:0] image [16];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compares both instances; only the instruction word differs by endianness.
  task automatic check_state(input string tag, input logic [31:0] pc_o,
                             input logic [31:0] ibe, input logic [31:0] ile,
                             input logic [31:0] ipc, input logic [31:0] ipc4,
                             input logic valid, input logic fault);
    check({tag, " be pc_o"},  be_pc_o,  pc_o);
    check({tag, " be instr"}, be_instr, ibe);
    check({tag, " be ipc"},   be_ipc,   ipc);
    check({tag, " be ipc4"},  be_ipc4,  ipc4);
    check({tag, " be valid"}, 32'(be_valid), 32'(valid));
    check({tag, " be fault"}, 32'(be_fault), 32'(fault));
    check({tag, " le pc_o"},  le_pc_o,  pc_o);
    check({tag, " le instr"}, le_instr, ile);
    check({tag, " le ipc"},   le_ipc,   ipc);
    check({tag, " le ipc4"},  le_ipc4,  ipc4);
    check({tag, " le valid"}, 32'(le_valid), 32'(valid));
    check({tag, " le fault"}, 32'(le_fault), 32'(fault));
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pw, input logic rv, input logic [31:0] rpc,
                       input logic fl);
    pc_write       = pw;
    redirect_valid = rv;
    redirect_pc    = rpc;
    flush          = fl;
  endtask

  initial begin
    // Word 0: 00038823, 4: 00029486, 8: AABBCCDD, 12: 01020304 (big-endian view)
    image = '{8'h00, 8'h03, 8'h88, 8'h23, 8'h00, 8'h02, 8'h94, 8'h86,
              8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};

    //          pw    rv    fl    rpc     pc_o    instr_be      instr_le      ipc     ipc4    v     f
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'd0,  32'd4,  32'h00038823, 32'h23880300, 32'd0,  32'd4,  1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'd0,  32'd4,  32'h00038823, 32'h23880300, 32'd0,  32'd4,  1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'd0,  32'd4,  32'h00038823, 32'h23880300, 32'd0,  32'd4,  1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'd0,  32'd4,  32'h00038823, 32'h23880300, 32'd0,  32'd4,  1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'd0,  32'd8,  32'h00029486, 32'h86940200, 32'd4,  32'd8,  1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'd12, 32'd12, NOP,          NOP,          32'd4,  32'd8,  1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'd0,  32'd16, 32'h01020304, 32'h04030201, 32'd12, 32'd16, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'd0,  32'd16, NOP,          NOP,          32'd12, 32'd16, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'd0,  32'd16, NOP,          NOP,          32'd12, 32'd16, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'd0,  32'd20, NOP,          NOP,          32'd16, 32'd20, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 32'd8,  32'd8,  NOP,          NOP,          32'd16, 32'd20, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 32'd0,  32'd12, 32'hAABBCCDD, 32'hDDCCBBAA, 32'd8,  32'd12, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 32'd0,  32'd16, NOP,          NOP,          32'd8,  32'd12, 1'b0, 1'b1};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    prog_we   = 1'b0;
    prog_addr = 32'd0;
    prog_data = 8'h00;

    // Load the program while reset holds the pipeline.
    #2;
    for (int i = 0; i < 16; i++) begin
      prog_we   = 1'b1;
      prog_addr = 32'(i);
      prog_data = image[i];
      step();
    end
    prog_we = 1'b0;

    check_state("reset", 32'd0, NOP, NOP, 32'd0, 32'd0, 1'b0, 1'b0);

    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].pw, vecs[i].rv, vecs[i].rpc, vecs[i].fl);
      step();
      check_state($sformatf("vec%0d", i), vecs[i].e_pc_o, vecs[i].e_instr_be,
                  vecs[i].e_instr_le, vecs[i].e_ipc, vecs[i].e_ipc4,
                  vecs[i].e_valid, vecs[i].e_fault);
    end

    // Async reset in the middle of a stall, away from any clock edge.
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    step();
    #2 rst_n = 1'b0;
    #1;
    check_state("async_rst", 32'd0, NOP, NOP, 32'd0, 32'd0, 1'b0, 1'b0);

    // Misaligned redirect on the first edge out of reset, stalled PC_write.
    step();
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 32'd6, 1'b0);
    step();
    check_state("misalign", 32'd4, NOP, NOP, 32'd0, 32'd0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    step();
    check_state("after_misalign", 32'd8, 32'h00029486, 32'h86940200,
                32'd4, 32'd8, 1'b1, 1'b1);

    // PC wrap: last word of the address space, then +4 wraps to 0.
    drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step();
    check_state("redir_top", 32'hFFFF_FFFC, NOP, NOP, 32'd4, 32'd8, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    step();
    check_state("wrap", 32'd0, NOP, NOP, 32'hFFFF_FFFC, 32'd0, 1'b1, 1'b1);

    // Sticky fault clears only on reset.
    #2 rst_n = 1'b0;
    #1;
    check_state("fault_clr", 32'd0, NOP, NOP, 32'd0, 32'd0, 1'b0, 1'b0);

    // Program port: write to the word being fetched is not bypassed.
    step();
    rst_n     = 1'b1;
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    prog_we   = 1'b1;
    prog_addr = 32'd3;
    prog_data = 8'hFF;
    step();
    check_state("no_bypass", 32'd4, 32'h00038823, 32'h23880300,
                32'd0, 32'd4, 1'b1, 1'b0);

    // Out-of-range write (would alias byte 0 if not rejected) plus redirect to 0.
    prog_addr = 32'd16;
    prog_data = 8'h55;
    drive(1'b0, 1'b1, 32'd0, 1'b0);
    step();
    check_state("redir0", 32'd0, NOP, NOP, 32'd0, 32'd4, 1'b0, 1'b0);

    prog_we = 1'b0;
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    step();
    check_state("prog_seen", 32'd4, 32'h000388FF, 32'hFF880300,
                32'd0, 32'd4, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
